// File: rtl/load_ctrl_if.sv
// load_ctrl_if -- SRAM-like data bus between the M-stage load controller and
// the data-cache/bridge port.
//
//   data_req      master -> slave  read request
//   data_addr     master -> slave  byte address
//   data_size     master -> slave  0 = byte, 1 = half, 2 = word
//   data_addr_ok  slave -> master  request accepted
//   data_data_ok  slave -> master  read data valid
//   data_rdata    slave -> master  read data
interface load_ctrl_if;
  logic        data_req;
  logic [31:0] data_addr;
  logic [1:0]  data_size;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_addr, data_size,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_addr, data_size,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/load_ctrl.sv
// load_ctrl -- memory-stage load controller.
// Issues one bus read for LB/LBU/LH/LHU/LW in M, stalls the pipeline until
// the data returns, then extends the addressed byte/halfword and holds it
// for writeback.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   opM             M-stage opcode
//   aluoutM         M-stage effective address
//   excepttypeM     nonzero: M instruction already excepting, no load issued
//   flushM, stallM  M-stage flush / hold from another source
//   bus             data bus (load_ctrl_if.master)
//   readdataM       extended load result
//   load_stallM     stall request to hazard unit
//   adelM           load address-error flag
//
// Build option: LOAD_ALIGN_CHECK_EN -- when defined, misaligned LH/LHU/LW
// raise adelM and are not issued; when undefined, the low address bits are
// forced aligned and adelM is tied to 0.
//
// state | meaning
// IDLE  | no transaction; request driven combinationally for a valid load
// REQ   | request presented, waiting for data_addr_ok
// WAIT  | request accepted, waiting for data_data_ok
// DONE  | result held in readdataM, stall released
module load_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] excepttypeM,
  input  logic        flushM,
  input  logic        stallM,
  load_ctrl_if.master bus,
  output logic [31:0] readdataM,
  output logic        load_stallM,
  output logic        adelM
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LW  = 6'b100011;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic        discard_q, discard_d;
  logic [31:0] result_q, result_d;

  logic        is_byte, is_half, is_word, is_load;
  logic        load_valid;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext_data;

  assign is_byte = (opM == OP_LB) || (opM == OP_LBU);
  assign is_half = (opM == OP_LH) || (opM == OP_LHU);
  assign is_word = (opM == OP_LW);
  assign is_load = is_byte || is_half || is_word;

`ifdef LOAD_ALIGN_CHECK_EN
  assign adelM = (state_q == IDLE) && (excepttypeM == 32'd0) &&
                 ((is_half && aluoutM[0]) || (is_word && (aluoutM[1:0] != 2'b00)));
  assign bus.data_addr = aluoutM;
`else
  assign adelM = 1'b0;
  always_comb begin
    bus.data_addr = aluoutM;
    if (is_half) bus.data_addr[0] = 1'b0;
    if (is_word) bus.data_addr[1:0] = 2'b00;
  end
`endif

  assign load_valid = is_load && (excepttypeM == 32'd0) && !flushM && !adelM;

  always_comb begin
    bus.data_size = 2'd2;
    if (is_byte) bus.data_size = 2'd0;
    else if (is_half) bus.data_size = 2'd1;
  end

  // Lane selection uses only the bits that matter for the access size, so a
  // misaligned address (check disabled) extracts from the aligned lane.
  always_comb begin
    case (aluoutM[1:0])
      2'd0:    byte_sel = bus.data_rdata[7:0];
      2'd1:    byte_sel = bus.data_rdata[15:8];
      2'd2:    byte_sel = bus.data_rdata[23:16];
      default: byte_sel = bus.data_rdata[31:24];
    endcase
    half_sel = aluoutM[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];
    case (opM)
      OP_LB:   ext_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  ext_data = {24'd0, byte_sel};
      OP_LH:   ext_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  ext_data = {16'd0, half_sel};
      default: ext_data = bus.data_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    discard_d    = discard_q;
    result_d     = result_q;
    bus.data_req = 1'b0;
    load_stallM  = 1'b0;
    case (state_q)
      IDLE: begin
        bus.data_req = load_valid;
        load_stallM  = load_valid;
        if (load_valid) state_d = bus.data_addr_ok ? WAIT : REQ;
      end
      REQ: begin
        // The presented request must stay up until accepted, even if flushed.
        bus.data_req = 1'b1;
        load_stallM  = 1'b1;
        if (flushM) discard_d = 1'b1;
        if (bus.data_addr_ok) state_d = WAIT;
      end
      WAIT: begin
        load_stallM = 1'b1;
        if (flushM) discard_d = 1'b1;
        if (bus.data_data_ok) begin
          if (discard_q || flushM) begin
            state_d = IDLE;
          end else begin
            result_d = ext_data;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        if (flushM || !stallM) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) discard_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      discard_q <= 1'b0;
      result_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      result_q  <= result_d;
    end
  end

  assign readdataM = result_q;

endmodule
